// File: rtl/add_sub_seq.sv
// add_sub_seq: multi-cycle two's-complement adder/subtractor.
// Operands are consumed CHUNK bits per clock, LSB chunk first. Results
// (S, Cout, V, Z) are committed in one step on the edge that enters DONE,
// so partial sums never appear on the outputs.
module add_sub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             Z
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;     // already inverted for subtract
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] acc_next;
    logic             carry_reg;
    logic [IW-1:0]    idx_reg;
    logic [CHUNK-1:0] a_cur;
    logic [CHUNK-1:0] b_cur;
    logic [CHUNK:0]   chunk_sum;
    logic             last_chunk;
    logic             capture;
    logic             v_next;

    // Pick the operand chunks addressed by the current index.
    always_comb begin
        a_cur = '0;
        b_cur = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_reg == IW'(i)) begin
                a_cur = a_reg[i*CHUNK +: CHUNK];
                b_cur = b_reg[i*CHUNK +: CHUNK];
            end
        end
    end

    // One CHUNK-wide ripple add per cycle; the top bit is the chunk carry.
    assign chunk_sum  = {1'b0, a_cur} + {1'b0, b_cur} + {{CHUNK{1'b0}}, carry_reg};
    assign last_chunk = (idx_reg == IW'(N - 1));

    // Signed overflow on the final chunk: operands share a sign that the sum
    // does not. This is equivalent to carry-in XOR carry-out at the MSB.
    assign v_next = (a_cur[CHUNK-1] == b_cur[CHUNK-1]) &&
                    (chunk_sum[CHUNK-1] != a_cur[CHUNK-1]);

    // Accumulator view with the current chunk merged in, so the commit on
    // the last chunk sees the complete result on the same edge.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_acc
            assign acc_next[gi*CHUNK +: CHUNK] = (idx_reg == IW'(gi)) ?
                chunk_sum[CHUNK-1:0] : acc_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; start is honoured in IDLE and DONE only.
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (last_chunk) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    capture    = 1'b1;
                    state_next = ST_BUSY;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state_reg == ST_BUSY);
    assign done = (state_reg == ST_DONE);

    // Operand capture and per-chunk accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
        end else if (capture) begin
            a_reg     <= A;
            b_reg     <= B ^ {WIDTH{mode}};
            acc_reg   <= '0;
            carry_reg <= mode;
            idx_reg   <= '0;
        end else if (state_reg == ST_BUSY) begin
            acc_reg   <= acc_next;
            carry_reg <= chunk_sum[CHUNK];
            if (!last_chunk) begin
                idx_reg <= idx_reg + 1'b1;
            end
        end
    end

    // Result commit on the last chunk; outputs hold until the next commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S    <= '0;
            Cout <= 1'b0;
            V    <= 1'b0;
            Z    <= 1'b0;
        end else if ((state_reg == ST_BUSY) && last_chunk) begin
            S    <= acc_next;
            Cout <= chunk_sum[CHUNK];
            V    <= v_next;
            Z    <= (acc_next == '0);
        end
    end

endmodule

// File: tb/tb_add_sub_seq.sv
// Directed bench for add_sub_seq: a 16/4 instance driven through a
// scoreboard queue, plus an 8/8 instance for the single-chunk case.
module tb_add_sub_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        mode;
    logic        busy;
    logic        done;
    logic [15:0] s_out;
    logic        cout;
    logic        v_out;
    logic        z_out;

    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        mode8;
    logic        busy8;
    logic        done8;
    logic [7:0]  s8;
    logic        cout8;
    logic        v8;
    logic        z8;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    add_sub_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a_in), .B(b_in),
        .mode(mode), .busy(busy), .done(done), .S(s_out), .Cout(cout),
        .V(v_out), .Z(z_out)
    );

    add_sub_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
        .mode(mode8), .busy(busy8), .done(done8), .S(s8), .Cout(cout8),
        .V(v8), .Z(z8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Independent reference: unsigned compare for carry, integer range for V.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic m);
        exp_t e;
        int   sa;
        int   sbv;
        int   r;
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        r   = m ? (sa - sbv) : (sa + sbv);
        e.s = m ? (a - b) : (a + b);
        e.c = m ? (a >= b) : ((32'(a) + 32'(b)) > 32'hFFFF);
        e.v = (r > 32767) || (r < -32768);
        e.z = (e.s == 16'h0);
        return e;
    endfunction

    task automatic push_exp(input logic [15:0] s, input logic c, input logic v, input logic z);
        exp_t e;
        e.s = s; e.c = c; e.v = v; e.z = z;
        sb.push_back(e);
    endtask

    // Drive start for one edge; returns one #1 after the capture edge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic m);
        a_in = a; b_in = b; mode = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a_in = 16'hDEAD; b_in = 16'hBEEF; mode = ~m;
    endtask

    // Wait for done, check latency and busy width, then pop and compare.
    task automatic wait_done(input string tag, input int exp_lat);
        int   cnt = 0;
        int   busy_n = 0;
        exp_t e;
        while (!done && cnt < 40) begin
            if (busy) busy_n++;
            @(posedge clk); #1;
            cnt++;
        end
        chk({tag, "_latency"}, cnt, exp_lat);
        chk({tag, "_busy_cycles"}, busy_n, exp_lat);
        if (done) begin
            chk({tag, "_busy_at_done"}, busy, 0);
            if (sb.size() == 0) begin
                chk({tag, "_scoreboard_empty"}, 1, 0);
            end else begin
                e = sb.pop_front();
                chk({tag, "_S"}, s_out, e.s);
                chk({tag, "_Cout"}, cout, e.c);
                chk({tag, "_V"}, v_out, e.v);
                chk({tag, "_Z"}, z_out, e.z);
                $display("[TB] %s A/B op -> S=%04h C=%0d V=%0d Z=%0d", tag, s_out, cout, v_out, z_out);
            end
        end
    endtask

    initial begin
        int   t_first;
        int   dn;
        int   cnt8;
        exp_t e;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rm;

        rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; mode = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; mode8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_outs", {s_out, cout, v_out, z_out}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic add and subtract cases
        push_exp(16'h000F, 0, 0, 0);
        start_op(16'h0003, 16'h000C, 0);
        wait_done("add3c", 4);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);

        push_exp(16'hFFFB, 0, 0, 0);
        start_op(16'h0005, 16'h000A, 1);
        wait_done("sub5a", 4);
        push_exp(16'h0005, 1, 0, 0);
        start_op(16'h000A, 16'h0005, 1);
        wait_done("suba5", 4);

        // Boundaries
        push_exp(16'h0000, 1, 0, 1);
        start_op(16'hFFFF, 16'h0001, 0);
        wait_done("wrap_zero", 4);
        push_exp(16'h8000, 0, 1, 0);
        start_op(16'h7FFF, 16'h0001, 0);
        wait_done("pos_ovf", 4);
        push_exp(16'h7FFF, 1, 1, 0);
        start_op(16'h8000, 16'h0001, 1);
        wait_done("neg_ovf", 4);

        // start while busy must be ignored
        push_exp(16'h000F, 0, 0, 0);
        start_op(16'h0003, 16'h000C, 0);
        a_in = 16'h1234; b_in = 16'h4321; mode = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ignore_busy", 3);

        // Back-to-back: start in the done cycle, S holds during BUSY
        t_first = cyc;
        e = model(16'h1111, 16'h2222, 0);
        sb.push_back(e);
        start_op(16'h1111, 16'h2222, 0);
        chk("hold_S_busy", s_out, 16'h000F);
        @(posedge clk); #1;
        chk("hold_S_busy2", s_out, 16'h000F);
        wait_done("b2b", 3);
        chk("b2b_spacing", cyc - t_first, 5);

        // Reset after two chunks abandons the op
        start_op(16'h0F0F, 16'h0101, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_outs", {s_out, cout, v_out, z_out}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) dn++;
            @(posedge clk); #1;
        end
        chk("mid_rst_no_done", dn, 0);
        e = model(16'h0F0F, 16'h0101, 0);
        sb.push_back(e);
        start_op(16'h0F0F, 16'h0101, 0);
        wait_done("after_rst", 4);

        // Random operations against the reference model
        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rm = 1'($urandom_range(0, 1));
            e = model(ra, rb, rm);
            sb.push_back(e);
            start_op(ra, rb, rm);
            wait_done($sformatf("rand%0d", i), 4);
        end
        chk("scoreboard_drained", sb.size(), 0);

        // Single-chunk instance
        a8 = 8'h80; b8 = 8'h80; mode8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        cnt8 = 0;
        while (!done8 && cnt8 < 20) begin
            @(posedge clk); #1;
            cnt8++;
        end
        chk("w8_latency", cnt8, 1);
        chk("w8_S", s8, 8'h00);
        chk("w8_Cout", cout8, 1);
        chk("w8_V", v8, 1);
        chk("w8_Z", z8, 1);
        $display("[TB] w8 80+80 -> S=%02h C=%0d V=%0d Z=%0d", s8, cout8, v8, z8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // busy and done must never be high together.
    always @(negedge clk) begin
        if (rst_n && busy && done) begin
            tests++;
            fails++;
            $error("FAIL busy_done_overlap: observed 1 expected 0");
        end
    end

endmodule
